qpmm_redundant_resolve: RTL

QPMM_REDUNDANT_RESOLVE -- requirements
Module: qpmm_redundant_resolve

---
 rtl/qpmm_redundant_resolve.sv | 127 ++++++++++++
 1 files changed

// File: rtl/qpmm_redundant_resolve.sv
// rtl/qpmm_redundant_resolve.sv - carry-resolve and reduce a 4-term redundant operand modulo the BN254 prime
module qpmm_redundant_resolve (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [303:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [271:0] out_data,
    output logic         out_err
);

    localparam logic [280:0] MOD  = 281'h2523648240000001ba344d80000000086121000000000013a700000000000013;
    localparam logic [280:0] MOD2 = MOD << 1;
    localparam logic [280:0] MOD4 = MOD << 2;
    localparam logic [280:0] MOD8 = MOD << 3;

    typedef enum logic [1:0] {IDLE, CARRY, RED, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        k;          // term index in CARRY, reduction step in RED
    logic [3:0][75:0]  din;        // captured operand, one 76-bit term per entry
    logic [8:0]        cin;
    logic [280:0]      r;          // resolved value, then partially reduced value
    logic              err;

    logic [75:0]       term;
    logic [68:0]       acc;
    logic [8:0]        cin_next;
    logic [280:0]      step_mod;
    logic              err_now;
    logic [280:0]      r_red;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign out_err   = out_valid && err;

    // Carry step for the current term: low 68 bits are final, overflow plus the term's own carry moves up.
    always_comb begin
        term     = din[k];
        acc      = {1'b0, term[67:0]} + {60'd0, cin};
        cin_next = {8'd0, acc[68]} + {1'b0, term[75:68]};
    end

    // Binary-weighted conditional subtraction; the range check happens on the first step and then freezes r.
    always_comb begin
        step_mod = MOD;
        case (k)
            2'd0:    step_mod = MOD4;
            2'd1:    step_mod = MOD2;
            default: step_mod = MOD;
        endcase
        err_now = (k == 2'd0) ? (r >= MOD8) : err;
        r_red   = r;
        if (!err_now && (r >= step_mod)) begin
            r_red = r - step_mod;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: 4 carry cycles and 3 reduction cycles give a fixed 7-edge latency.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = CARRY;
            CARRY:   if (k == 2'd3) state_next = RED;
            RED:     if (k == 2'd2) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture on accept, resolve one term per cycle, then reduce and latch the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            din      <= '0;
            k        <= 2'd0;
            cin      <= 9'd0;
            r        <= '0;
            err      <= 1'b0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        din <= in_data;
                        cin <= 9'd0;
                        k   <= 2'd0;
                        err <= 1'b0;
                    end
                end
                CARRY: begin
                    case (k)
                        2'd0:    r[67:0]    <= acc[67:0];
                        2'd1:    r[135:68]  <= acc[67:0];
                        2'd2:    r[203:136] <= acc[67:0];
                        default: r[280:204] <= {cin_next, acc[67:0]};
                    endcase
                    cin <= cin_next;
                    k   <= k + 2'd1;
                end
                RED: begin
                    r   <= r_red;
                    err <= err_now;
                    if (k == 2'd2) begin
                        k        <= 2'd0;
                        out_data <= r_red[271:0];
                    end else begin
                        k <= k + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
